axis_mux_n: RTL and testbench
=============================

Name: axis_mux_n

Overview:
- N-input AXI-Stream multiplexer and next-generation 2:1 stream mux; parametrised in channel count and data width.
- Adds packet-locked arbitration: a grant is held from first beat to tlast.
- Two modes: external select, or fair round-robin.
- Registered output with a skid stage, so s_tready never depends combinationally on m_tready; full 1 beat/cycle throughput.
- Sits between multiple stream producers and a single downstream consumer, replacing the 2:1 mux.

Parameters:
- NUM_CH, 4, number of slave channels; legal range 2..16.
- DW, 8, tdata width in bits.
- MODE, 0; 0 = external sel chooses the channel, 1 = round-robin among valid channels.
- IDW, $clog2(NUM_CH), width of sel and m_tid.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- sel  in  IDW  channel select; used only when MODE=0 and not locked.
- s_tdata  in  NUM_CH*DW  channel i occupies bits [i*DW +: DW].
- s_tvalid  in  NUM_CH  per-channel valid.
- s_tlast  in  NUM_CH  per-channel end-of-packet.
- s_tready  out  NUM_CH  per-channel ready; at most one bit high per cycle.
- m_tdata  out  DW  output data.
- m_tvalid  out  1  output valid.
- m_tlast  out  1  output end-of-packet.
- m_tid  out  IDW  source channel index of the current output beat.
- m_tready  in  1  downstream ready.
- busy  out  1  high while a multi-beat packet is locked.

Behaviour:
- Reset (rst=0, async):
  - m_tvalid=0, m_tdata=0, m_tlast=0, m_tid=0, busy=0, s_tready=0.
  - Skid buffer is emptied; arbiter goes to IDLE; round-robin pointer set to NUM_CH-1 (so channel 0 is first priority).
  - A ready-enable flop (reset 0) holds all s_tready low in the first cycle after release.
- Handshake:
  - A beat transfers on any interface when tvalid && tready at the rising edge.
  - A beat in the output register is never dropped or altered while m_tvalid=1 and m_tready=0.
- Output stage: main register plus one skid register.
  - A beat accepted at edge k appears on m_* after edge k (latency 1) when the main register is empty or draining.
  - If main is held (m_tvalid && !m_tready) when a beat is accepted, that beat goes to skid.
  - s_tready is 0 for every channel whenever skid is full.
  - When m_tready pops main, skid moves into main in the same edge.
- Arbiter states: IDLE and LOCK.
  - IDLE, MODE=0: candidate = sel. Granted only if s_tvalid[sel]=1; otherwise no channel is ready.
  - IDLE, MODE=1: candidate = first valid channel searching upward from ptr+1, modulo NUM_CH.
  - IDLE grant is combinational from the valids; the first beat is accepted in the same cycle.
  - IDLE to LOCK: accepted first beat with tlast=0. Latch grant, set busy=1.
  - IDLE to IDLE: accepted beat with tlast=1 (single-beat packet). In MODE=1, ptr is set to the granted channel.
  - LOCK: only the locked channel's s_tready can be high. sel changes and other channels' valids are ignored.
  - LOCK to IDLE: accepted beat with tlast=1. busy=0 on the next cycle; in MODE=1, ptr is set to the locked channel.
  - In LOCK with the locked channel's s_tvalid=0, wait indefinitely; there is no timeout.
- m_tid equals the grant index captured with each beat and travels with it through the skid stage.
- Simultaneous events: a main pop and a new accept at the same edge give no bubble and no skid usage; throughput is 1 beat/cycle.
- Reset mid-packet aborts the packet. A partial packet already emitted is not terminated with tlast; upstream is responsible.
- Out-of-range sel (value >= NUM_CH) grants nothing.

Decomposition:
- Package axis_mux_pkg holds:
  - the arb_state_e enum (IDLE, LOCK);
  - mode localparams MODE_SEL=0 and MODE_RR=1;
  - a beat struct {data, last, id}, parametrised through the module.
- One sub-module, axis_skid_reg, holding the main+skid output register, with a DW+1+IDW-wide payload; it is reusable elsewhere.
- Arbiter logic stays in axis_mux_n.

Test Plan:
- Reset/release: hold rst=0 with all s_tvalid=1 -> s_tready=0 and m_tvalid=0. In the first cycle after release s_tready is still 0; from the second cycle, the granted channel is ready.
- MODE=0, packet lock: sel=1, channel 1 sends 3 beats (0xA1, 0xA2, 0xA3 with last); sel switches to 2 after beat 1 -> m_tdata sequence A1, A2, A3 with m_tid=1, busy high until A3 accepted, then channel 2 is granted.
- MODE=1 fairness: NUM_CH=4, all channels continuously valid with 1-beat packets -> m_tid sequence 0, 1, 2, 3, 0, 1 with no idle cycle between beats.
- Backpressure: a 4-beat packet with m_tready toggled 1,0,0,1,1,0,1 -> all 4 beats arrive in order exactly once, s_tready low while skid is full, and no s_tready bit depends combinationally on m_tready.
- Reset mid-packet: assert rst after beat 2 of 5 -> outputs go to 0 immediately; after release, arbitration restarts in IDLE and channel 0 wins in MODE=1.
- Invalid sel: MODE=0, NUM_CH=3, sel=3 with all valids high -> no s_tready asserted and m_tvalid stays 0.

Source files
------------

// File: rtl/axis_mux_pkg.sv
// Shared types for the N-input stream mux: arbiter states and mode selectors.
// The beat struct lives in axis_mux_n because its field widths come from that module's parameters.
package axis_mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

endpackage

// File: rtl/axis_skid_reg.sv
// Main + skid output register for a valid/ready stream, latency 1, full throughput.
// o_s_rdy comes only from the skid flop, so upstream never sees i_m_rdy combinationally.
module axis_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_s_vld,
    output logic         o_s_rdy,
    input  logic [W-1:0] i_s_dat,
    output logic         o_m_vld,
    input  logic         i_m_rdy,
    output logic [W-1:0] o_m_dat
);

    logic         r_main_vld;
    logic         r_skid_vld;
    logic [W-1:0] r_main_dat;
    logic [W-1:0] r_skid_dat;
    logic         w_acc;
    logic         w_main_free;

    assign o_s_rdy     = !r_skid_vld;
    assign w_acc       = i_s_vld && !r_skid_vld;
    assign w_main_free = !r_main_vld || i_m_rdy;
    assign o_m_vld     = r_main_vld;
    assign o_m_dat     = r_main_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
            r_main_dat <= '0;
            r_skid_dat <= '0;
        end else if (w_main_free) begin
            // A full skid blocks new accepts, so it only ever refills main here.
            if (r_skid_vld) begin
                r_main_vld <= 1'b1;
                r_main_dat <= r_skid_dat;
                r_skid_vld <= 1'b0;
            end else begin
                r_main_vld <= w_acc;
                if (w_acc) begin
                    r_main_dat <= i_s_dat;
                end
            end
        end else if (w_acc) begin
            r_skid_vld <= 1'b1;
            r_skid_dat <= i_s_dat;
        end
    end

endmodule

// File: rtl/axis_mux_n.sv
// N:1 AXI-Stream mux with packet-locked grant (external select or round-robin), latency 1 beat.
// Backpressure absorbed by a skid stage; s_tready depends on valids and registered state only.
module axis_mux_n
    import axis_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DW     = 8,
    parameter int MODE   = 0,
    parameter int IDW    = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDW-1:0]       sel,
    input  logic [NUM_CH*DW-1:0] s_tdata,
    input  logic [NUM_CH-1:0]    s_tvalid,
    input  logic [NUM_CH-1:0]    s_tlast,
    output logic [NUM_CH-1:0]    s_tready,
    output logic [DW-1:0]        m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    output logic [IDW-1:0]       m_tid,
    input  logic                 m_tready,
    output logic                 busy
);

    typedef struct packed {
        logic [DW-1:0]  data;
        logic           last;
        logic [IDW-1:0] id;
    } beat_t;

    arb_state_e     r_state;
    logic [IDW-1:0] r_lock_ch;
    logic [IDW-1:0] r_ptr;
    logic           r_rdy_en;

    logic [IDW-1:0] w_cand;
    logic           w_cand_ok;
    logic           w_skid_rdy;
    logic           w_acc;
    beat_t          w_beat;
    beat_t          w_out;

    always_comb begin
        w_cand    = '0;
        w_cand_ok = 1'b0;
        if (r_state == LOCK) begin
            w_cand    = r_lock_ch;
            w_cand_ok = 1'b1;
        end else if (MODE == MODE_SEL) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (IDW'(i) == sel && s_tvalid[i]) begin
                    w_cand    = IDW'(i);
                    w_cand_ok = 1'b1;
                end
            end
        end else begin
            // Lowest index wins in each pass; channels above ptr override the wrapped ones.
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (s_tvalid[i] && IDW'(i) <= r_ptr) begin
                    w_cand    = IDW'(i);
                    w_cand_ok = 1'b1;
                end
            end
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (s_tvalid[i] && IDW'(i) > r_ptr) begin
                    w_cand    = IDW'(i);
                    w_cand_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        s_tready = '0;
        w_beat   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (IDW'(i) == w_cand) begin
                s_tready[i] = w_cand_ok && r_rdy_en && w_skid_rdy;
                w_beat.data = s_tdata[i*DW +: DW];
                w_beat.last = s_tlast[i];
            end
        end
        w_beat.id = w_cand;
    end

    assign w_acc = |(s_tvalid & s_tready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_lock_ch <= '0;
            r_ptr     <= IDW'(NUM_CH - 1);
            r_rdy_en  <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_acc) begin
                if (r_state == IDLE) begin
                    if (!w_beat.last) begin
                        r_state   <= LOCK;
                        r_lock_ch <= w_cand;
                    end else if (MODE == MODE_RR) begin
                        r_ptr <= w_cand;
                    end
                end else if (w_beat.last) begin
                    r_state <= IDLE;
                    if (MODE == MODE_RR) begin
                        r_ptr <= r_lock_ch;
                    end
                end
            end
        end
    end

    axis_skid_reg #(
        .W($bits(beat_t))
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst),
        .i_s_vld (w_acc),
        .o_s_rdy (w_skid_rdy),
        .i_s_dat (w_beat),
        .o_m_vld (m_tvalid),
        .i_m_rdy (m_tready),
        .o_m_dat (w_out)
    );

    assign m_tdata = w_out.data;
    assign m_tlast = w_out.last;
    assign m_tid   = w_out.id;
    assign busy    = (r_state == LOCK);

endmodule

// File: tb/tb_axis_mux_n.sv
// Directed bench: one select-mode and one round-robin mux on shared inputs, plus a 3-channel mux
// held on an out-of-range select.
module tb_axis_mux_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sel;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tlast;
    logic        m_tready;

    logic [3:0]  a_tready, b_tready;
    logic [7:0]  a_tdata, b_tdata;
    logic        a_tvalid, b_tvalid, a_tlast, b_tlast, a_busy, b_busy;
    logic [1:0]  a_tid, b_tid;

    logic [1:0]  sel3;
    logic [23:0] s3_tdata;
    logic [2:0]  s3_tvalid, s3_tlast, c_tready;
    logic [7:0]  c_tdata;
    logic        c_tvalid, c_tlast, c_busy;
    logic [1:0]  c_tid;

    int n_checks = 0;
    int n_errors = 0;
    int b, nrx;
    logic [7:0] rx_dat[8];
    logic       rx_last[8];
    bit bp_pat[7]  = '{1, 0, 0, 1, 1, 0, 1};
    bit bp_rdy[7]  = '{1, 1, 0, 0, 1, 1, 0};

    always #5 clk = ~clk;

    axis_mux_n #(.NUM_CH(4), .DW(8), .MODE(0)) u_sel (
        .clk(clk), .rst(rst), .sel(sel),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(a_tready),
        .m_tdata(a_tdata), .m_tvalid(a_tvalid), .m_tlast(a_tlast), .m_tid(a_tid),
        .m_tready(m_tready), .busy(a_busy)
    );

    axis_mux_n #(.NUM_CH(4), .DW(8), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .sel(sel),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(b_tready),
        .m_tdata(b_tdata), .m_tvalid(b_tvalid), .m_tlast(b_tlast), .m_tid(b_tid),
        .m_tready(m_tready), .busy(b_busy)
    );

    axis_mux_n #(.NUM_CH(3), .DW(8), .MODE(0)) u_s3 (
        .clk(clk), .rst(rst), .sel(sel3),
        .s_tdata(s3_tdata), .s_tvalid(s3_tvalid), .s_tlast(s3_tlast), .s_tready(c_tready),
        .m_tdata(c_tdata), .m_tvalid(c_tvalid), .m_tlast(c_tlast), .m_tid(c_tid),
        .m_tready(m_tready), .busy(c_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        s_tvalid = '0;
        s_tlast  = '0;
        rst      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        sel       = 2'd0;
        m_tready  = 1'b1;
        s_tdata   = {8'h13, 8'h12, 8'h11, 8'h10};
        s_tvalid  = 4'hF;
        s_tlast   = 4'hF;
        sel3      = 2'd3;
        s3_tdata  = {8'h33, 8'h32, 8'h31};
        s3_tvalid = 3'b111;
        s3_tlast  = 3'b111;

        // Reset held with every channel valid.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sel_rdy", a_tready, 4'h0);
        check("rst_rr_rdy", b_tready, 4'h0);
        check("rst_vld", a_tvalid, 0);
        check("rst_data", a_tdata, 0);
        check("rst_last", a_tlast, 0);
        check("rst_tid", a_tid, 0);
        check("rst_busy", a_busy, 0);
        rst = 1'b1;
        #1;
        check("rel_sel_rdy", a_tready, 4'h0);
        check("rel_rr_rdy", b_tready, 4'h0);
        @(negedge clk);
        check("rel2_sel_rdy", a_tready, 4'b0001);
        check("rel2_rr_rdy", b_tready, 4'b0001);
        check("rel2_vld", b_tvalid, 0);

        // Round-robin over four always-valid single-beat channels.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_vld", b_tvalid, 1);
            check("rr_tid", b_tid, k % 4);
            check("rr_data", b_tdata, 8'h10 + k % 4);
        end

        // Select mode: packet on channel 1 holds the grant across a sel change.
        apply_reset();
        sel      = 2'd1;
        s_tdata  = {8'h00, 8'hB0, 8'hA1, 8'h00};
        s_tvalid = 4'b0110;
        s_tlast  = 4'b0100;
        @(negedge clk);
        check("lk_rdy0", a_tready, 4'b0010);
        @(posedge clk); #1;
        sel = 2'd2;
        s_tdata[15:8] = 8'hA2;
        @(negedge clk);
        check("lk_d1", a_tdata, 8'hA1);
        check("lk_id1", a_tid, 1);
        check("lk_busy1", a_busy, 1);
        check("lk_rdy1", a_tready, 4'b0010);
        @(posedge clk); #1;
        s_tdata[15:8] = 8'hA3;
        s_tlast[1] = 1'b1;
        @(negedge clk);
        check("lk_d2", a_tdata, 8'hA2);
        check("lk_last2", a_tlast, 0);
        check("lk_busy2", a_busy, 1);
        @(posedge clk); #1;
        s_tvalid[1] = 1'b0;
        @(negedge clk);
        check("lk_d3", a_tdata, 8'hA3);
        check("lk_last3", a_tlast, 1);
        check("lk_busy3", a_busy, 0);
        check("lk_rdy3", a_tready, 4'b0100);
        @(posedge clk); #1;
        s_tvalid = '0;
        @(negedge clk);
        check("lk_d4", a_tdata, 8'hB0);
        check("lk_id4", a_tid, 2);

        // Backpressure: 4-beat packet on channel 0 against a toggling m_tready.
        apply_reset();
        sel = 2'd0;
        s_tdata = '0;
        b = 0;
        nrx = 0;
        for (int c = 0; c < 10; c++) begin
            m_tready = (c < 7) ? bp_pat[c] : 1'b1;
            s_tvalid[0] = (b < 4);
            s_tdata[7:0] = 8'(8'hC1 + b);
            s_tlast[0] = (b == 3);
            @(negedge clk);
            if (c < 7) check("bp_rdy", a_tready[0], bp_rdy[c]);
            if (c == 2) begin
                m_tready = 1'b1;
                #1;
                check("bp_comb", a_tready, 4'h0);
                m_tready = 1'b0;
                #1;
            end
            if (a_tvalid && m_tready && nrx < 8) begin
                rx_dat[nrx]  = a_tdata;
                rx_last[nrx] = a_tlast;
                nrx++;
            end
            if (s_tvalid[0] && a_tready[0]) b++;
            @(posedge clk); #1;
        end
        check("bp_count", nrx, 4);
        for (int k = 0; k < 4; k++) begin
            check("bp_data", rx_dat[k], 8'hC1 + k);
            check("bp_last", rx_last[k], (k == 3));
        end

        // Reset in the middle of a round-robin packet.
        apply_reset();
        m_tready = 1'b1;
        s_tdata  = {8'h00, 8'hD0, 8'h00, 8'h00};
        s_tvalid = 4'b0100;
        s_tlast  = 4'b0000;
        @(posedge clk); #1;
        s_tdata[23:16] = 8'hD1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_vld", b_tvalid, 1);
        check("mid_data", b_tdata, 8'hD1);
        check("mid_busy", b_busy, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_vld", b_tvalid, 0);
        check("mid_rst_data", b_tdata, 0);
        check("mid_rst_busy", b_busy, 0);
        check("mid_rst_rdy", b_tready, 4'h0);
        s_tdata  = {8'h13, 8'h12, 8'h11, 8'h10};
        s_tvalid = 4'hF;
        s_tlast  = 4'hF;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rel_rdy", b_tready, 4'h0);
        @(negedge clk);
        check("mid_grant", b_tready, 4'b0001);
        @(negedge clk);
        check("mid_tid", b_tid, 0);
        check("mid_d0", b_tdata, 8'h10);

        // Out-of-range select on the 3-channel mux never grants.
        check("inv_rdy", c_tready, 3'b000);
        check("inv_vld", c_tvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
